mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares one single-port data memory between instruction fetch (IF, read-only) and the
// MEM stage (load/store). Grants one requester at a time, drives the registered memory
// port, waits on a variable-latency mem_ready handshake, returns data and drives stalls.
// Sits between the pipeline (IF stage, MEM-stage access logic) and the external memory.
// PARAMETERS
// AW          32   address width
// DW          32   data width (byte strobes = DW/8)
// D_STREAK    3    max consecutive MEM grants while IF is waiting; next grant forced to IF
// TIMEOUT     64   cycles in BUSY without mem_ready before abort (0 = never abort)
// PORTS
// clk         in   1      clock, all state on rising edge
// rst_n       in   1      asynchronous active-low reset
// if_req      in   1      IF read request, held until if_valid
// if_addr     in   AW     IF address
// if_rdata    out  DW     IF read data, valid with if_valid
// if_valid    out  1      one-cycle completion pulse for IF
// dm_req      in   1      MEM-stage request, held until dm_valid
// dm_we       in   1      1 = store, 0 = load
// dm_addr     in   AW     MEM-stage address
// dm_wdata    in   DW     store data
// dm_be       in   DW/8   store byte strobes
// dm_rdata    out  DW     load data, valid with dm_valid
// dm_valid    out  1      one-cycle completion pulse for MEM stage
// if_stall    out  1      if_req & ~if_valid (combinational)
// dm_stall    out  1      dm_req & ~dm_valid (combinational)
// mem_addr    out  AW     memory address (registered)
// mem_wdata   out  DW     memory write data (registered)
// mem_be      out  DW/8   memory byte strobes (registered; 0 on reads)
// mem_read    out  1      memory read strobe, high throughout BUSY for a read
// mem_write   out  1      memory write strobe, high throughout BUSY for a write
// mem_rdata   in   DW     memory read data, sampled on edge where mem_ready=1
// mem_ready   in   1      memory completion; sampled only in BUSY
// err         out  1      sticky: a transaction timed out; cleared only by reset
// BEHAVIOUR
// - Reset: state IDLE; all outputs, streak counter, timeout counter, err = 0.
// - FSM IDLE -> BUSY -> DONE -> IDLE. One transaction at a time; no pipelining.
// - IDLE: if any req, grant on this edge: latch addr/wdata/be/we into mem_* regs, set
//   mem_read or mem_write, record owner, go BUSY. No req: stay IDLE, strobes 0.
// - Priority: MEM over IF, except when streak==D_STREAK and if_req=1 -> grant IF.
//   Streak: +1 per MEM grant while if_req=1, saturates at D_STREAK; cleared on IF grant
//   or on MEM grant with if_req=0.
// - BUSY: addr/data/strobes stable. Edge with mem_ready=1: capture mem_rdata into owner's
//   rdata (loads/fetches only; stores leave dm_rdata unchanged), drop strobes, go DONE.
// - Timeout: counter cleared on entering BUSY, +1 per BUSY cycle without mem_ready; on
//   reaching TIMEOUT: drop strobes, set err, owner rdata = 0, go DONE.
// - DONE: owner's valid high exactly this cycle; go IDLE. Requests sampled in DONE are
//   ignored, so a held request is never granted twice.
// - Minimum latency: req seen at edge N, mem_ready high at edge N+1, valid in cycle
//   after edge N+1 (2 cycles req to valid). Next grant earliest at edge after DONE.
// - Simultaneous if_req & dm_req in IDLE: priority rule decides; loser stays stalled.
// - Requester dropping req while BUSY: transaction still completes, valid still pulses.
// - mem_ready outside BUSY: ignored. Reset mid-transaction: aborted, all outputs to 0.
// TESTING
// 1 Reset with rst_n low mid-BUSY -> mem_read/mem_write/valids/err = 0 immediately, IDLE.
// 2 if_req addr 0x100, mem_ready 1 cycle after grant, mem_rdata 0xDEADBEEF ->
//   if_valid pulses 1 cycle with if_rdata 0xDEADBEEF, 2 cycles after req.
// 3 dm_req store addr 0x40 wdata 0x12345678 be 0xF, ready after 3 cycles ->
//   mem_write high 3 cycles with stable addr/data, dm_valid one pulse, dm_rdata unchanged.
// 4 if_req and dm_req both held continuously (D_STREAK=3) -> grant order MEM,MEM,MEM,IF,
//   repeating; if_stall high until each if_valid.
// 5 mem_ready held 0, TIMEOUT=64 -> strobes drop after 64 BUSY cycles, err=1 sticky,
//   dm_valid pulses with dm_rdata 0; later transactions still work.
// 6 mem_ready pulsed while IDLE/DONE -> no valid, no state change.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port data memory between instruction fetch and the MEM stage.
// One transaction at a time: IDLE grants, BUSY waits on mem_ready (or times out), DONE pulses valid.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int D_STREAK = 3,
    parameter int TIMEOUT  = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic [DW-1:0]   if_rdata,
    output logic            if_valid,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    input  logic [DW/8-1:0] dm_be,
    output logic [DW-1:0]   dm_rdata,
    output logic            dm_valid,
    output logic            if_stall,
    output logic            dm_stall,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    output logic            mem_read,
    output logic            mem_write,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ready,
    output logic            err,
    output logic [1:0]      fsm_state
);
    // Handshake: a requester holds req (and its address/data) until its valid pulses for one
    // cycle; the memory holds nothing, it completes the current strobe with a one-cycle mem_ready.

    localparam int SW = (D_STREAK > 0) ? $clog2(D_STREAK + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          owner_dm;
    logic [SW-1:0] streak;
    logic [TW-1:0] tmo_cnt;
    logic          streak_full;
    logic          grant_if;
    logic          grant_dm;
    logic          tmo_hit;

    // MEM wins unless it has starved a waiting fetch D_STREAK times in a row.
    assign streak_full = (streak == SW'(D_STREAK));
    assign grant_if    = if_req & (~dm_req | streak_full);
    assign grant_dm    = dm_req & ~grant_if;
    assign tmo_hit     = (TIMEOUT != 0) && !mem_ready && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (if_req || dm_req) state_next = S_BUSY;
            S_BUSY:  if (mem_ready || tmo_hit) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        if_valid  = (state == S_DONE) && !owner_dm;
        dm_valid  = (state == S_DONE) && owner_dm;
        if_stall  = if_req & ~if_valid;
        dm_stall  = dm_req & ~dm_valid;
        fsm_state = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            owner_dm  <= 1'b0;
            streak    <= '0;
            tmo_cnt   <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    tmo_cnt <= '0;
                    if (grant_if) begin
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_be    <= '0;
                        mem_read  <= 1'b1;
                        mem_write <= 1'b0;
                        owner_dm  <= 1'b0;
                        streak    <= '0;
                    end else if (grant_dm) begin
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_be    <= dm_we ? dm_be : '0;
                        mem_read  <= ~dm_we;
                        mem_write <= dm_we;
                        owner_dm  <= 1'b1;
                        if (!if_req) begin
                            streak <= '0;
                        end else if (!streak_full) begin
                            streak <= streak + SW'(1);
                        end
                    end
                end
                S_BUSY: begin
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        // Stores complete without touching the load data register.
                        if (mem_read) begin
                            if (owner_dm) dm_rdata <= mem_rdata;
                            else          if_rdata <= mem_rdata;
                        end
                    end else if (tmo_hit) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        err       <= 1'b1;
                        if (owner_dm) dm_rdata <= '0;
                        else          if_rdata <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table for single transactions, then
// hand-written sequences for starvation streaks, timeout and mid-transaction reset.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [BW-1:0] dm_be;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;
    logic          if_stall;
    logic          dm_stall;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          err;
    logic [1:0]    fsm_state;

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .D_STREAK(3), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .if_stall(if_stall), .dm_stall(dm_stall),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        dmr;
        logic        we;
        logic [31:0] dma;
        logic [31:0] dmw;
        logic [3:0]  be;
        logic        rdy;
        logic [31:0] rd;
        logic [1:0]  e_st;
        logic        e_rd;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic        e_ifv;
        logic [31:0] e_ifd;
        logic        e_dmv;
        logic [31:0] e_dmd;
        logic        e_ifs;
        logic        e_dms;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0;
        dm_wdata = '0; dm_be = '0; mem_rdata = '0; mem_ready = 1'b0;
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        if_req = v.ifr; if_addr = v.ifa; dm_req = v.dmr; dm_we = v.we; dm_addr = v.dma;
        dm_wdata = v.dmw; dm_be = v.be; mem_ready = v.rdy; mem_rdata = v.rd;
        @(negedge clk);
        chk($sformatf("v%0d_state", idx), 32'(fsm_state), 32'(v.e_st));
        chk($sformatf("v%0d_mem_read", idx), 32'(mem_read), 32'(v.e_rd));
        chk($sformatf("v%0d_mem_write", idx), 32'(mem_write), 32'(v.e_wr));
        chk($sformatf("v%0d_mem_addr", idx), mem_addr, v.e_addr);
        chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.e_wdata);
        chk($sformatf("v%0d_mem_be", idx), 32'(mem_be), 32'(v.e_be));
        chk($sformatf("v%0d_if_valid", idx), 32'(if_valid), 32'(v.e_ifv));
        chk($sformatf("v%0d_if_rdata", idx), if_rdata, v.e_ifd);
        chk($sformatf("v%0d_dm_valid", idx), 32'(dm_valid), 32'(v.e_dmv));
        chk($sformatf("v%0d_dm_rdata", idx), dm_rdata, v.e_dmd);
        chk($sformatf("v%0d_if_stall", idx), 32'(if_stall), 32'(v.e_ifs));
        chk($sformatf("v%0d_dm_stall", idx), 32'(dm_stall), 32'(v.e_dms));
    endtask

    initial begin
        // Fetch 0x100 with ready one cycle after grant.
        vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                     2'd1, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF,
                     2'd2, 1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                     2'd0, 1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0};
        // Store 0x40 with three BUSY cycles before ready.
        vecs[3]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678, 4'hF, 1'b0, 32'h0,
                     2'd1, 1'b0, 1'b1, 32'h40, 32'h12345678, 4'hF, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b1};
        vecs[4]  = vecs[3];
        vecs[5]  = vecs[3];
        vecs[6]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678, 4'hF, 1'b1, 32'hAAAAAAAA,
                     2'd2, 1'b0, 1'b0, 32'h40, 32'h12345678, 4'hF, 1'b0, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                     2'd0, 1'b0, 1'b0, 32'h40, 32'h12345678, 4'hF, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0};
        // Stray mem_ready while IDLE.
        vecs[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h55,
                     2'd0, 1'b0, 1'b0, 32'h40, 32'h12345678, 4'hF, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0};
        // Load 0x80: strobes zeroed on reads; request held through DONE is not regranted.
        vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 1'b0, 32'h0,
                     2'd1, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 1'b1, 32'hCAFEF00D,
                     2'd2, 1'b0, 1'b0, 32'h80, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 1'b1, 32'h11111111,
                     2'd0, 1'b0, 1'b0, 32'h80, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                     2'd0, 1'b0, 1'b0, 32'h80, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0};

        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(fsm_state), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_valids", 32'({if_valid, dm_valid}), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) apply_vec(i, vecs[i]);

        // Both requesters held: MEM,MEM,MEM,IF repeating; memory returns addr+0x1000.
        begin
            logic exp_dm [8];
            int g;
            int cyc;
            exp_dm = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
            g = 0;
            cyc = 0;
            if_req = 1'b1; if_addr = 32'h200;
            dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; dm_be = 4'h0; mem_ready = 1'b1;
            while (g < 8 && cyc < 60) begin
                mem_rdata = mem_addr + 32'h1000;
                @(negedge clk);
                cyc++;
                if (fsm_state == 2'd1) begin
                    chk($sformatf("streak_grant%0d", g), mem_addr, exp_dm[g] ? 32'h300 : 32'h200);
                    g++;
                end
                if (if_valid) chk("streak_if_rdata", if_rdata, 32'h1200);
                chk("streak_if_stall", 32'(if_stall), if_valid ? 32'd0 : 32'd1);
            end
            if (g < 8) chk("streak_grant_count", 32'(g), 32'd8);
            if_req = 1'b0; dm_req = 1'b0;
            mem_rdata = mem_addr + 32'h1000;
            repeat (3) @(negedge clk);
            mem_ready = 1'b0;
            @(negedge clk);
            chk("streak_end_state", 32'(fsm_state), 32'd0);
            chk("streak_end_err", 32'(err), 32'd0);
            chk("streak_dm_rdata", dm_rdata, 32'h1300);
        end

        // Timeout: mem_ready held low on a load.
        begin
            int hi;
            int cyc;
            logic seen;
            hi = 0;
            cyc = 0;
            seen = 1'b0;
            dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44; mem_ready = 1'b0; mem_rdata = 32'h99;
            while (!seen && cyc < 100) begin
                @(negedge clk);
                cyc++;
                if (mem_read) hi++;
                if (dm_valid) begin
                    seen = 1'b1;
                    chk("tmo_dm_rdata", dm_rdata, 32'h0);
                    chk("tmo_err", 32'(err), 32'd1);
                end
            end
            chk("tmo_valid_seen", 32'(seen), 32'd1);
            chk("tmo_busy_cycles", 32'(hi), 32'd64);
            dm_req = 1'b0;
            @(negedge clk);
            chk("tmo_valid_pulse", 32'(dm_valid), 32'd0);
            chk("tmo_back_idle", 32'(fsm_state), 32'd0);
            if_req = 1'b1; if_addr = 32'h104; mem_ready = 1'b1; mem_rdata = 32'h77;
            @(negedge clk);
            chk("post_tmo_busy", 32'(mem_read), 32'd1);
            @(negedge clk);
            chk("post_tmo_if_valid", 32'(if_valid), 32'd1);
            chk("post_tmo_if_rdata", if_rdata, 32'h77);
            chk("post_tmo_err_sticky", 32'(err), 32'd1);
            if_req = 1'b0; mem_ready = 1'b0;
            @(negedge clk);
        end

        // Reset asserted mid-BUSY takes effect without a clock edge.
        if_req = 1'b1; if_addr = 32'h108; mem_ready = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(mem_read), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mem_read", 32'(mem_read), 32'd0);
        chk("midrst_state", 32'(fsm_state), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_valids", 32'({if_valid, dm_valid}), 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        if_req = 1'b0;
        @(negedge clk);
        chk("midrst_after_state", 32'(fsm_state), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
